// File: rtl/image_mem_reader_pkg.sv
// Shared constants for the image buffer read path.
//   IMG_ADDR_BITS / IMG_DATA_WIDTH / IMG_DEPTH : geometry of the 1024x8 image buffer
//   ST_*                                       : reader FSM state encoding
package image_mem_reader_pkg;

  localparam int IMG_ADDR_BITS  = 10;
  localparam int IMG_DATA_WIDTH = 8;
  localparam int IMG_DEPTH      = 1 << IMG_ADDR_BITS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // The reader owns the memory address bus only while streaming or draining.
  function automatic logic is_busy_state(input logic [1:0] s);
    return (s == ST_STREAM) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/image_mem_reader_if.sv
// Bundle of command, memory-read and output-stream signals of the image reader.
//   command : start, base_addr, length -> busy, done
//   memory  : mem_addr -> mem_data (combinational read)
//   stream  : out_data/out_valid -> out_ready
// master = the reader, slave = the surrounding system (cmd source, memory, consumer).
interface image_mem_reader_if
  import image_mem_reader_pkg::*;
#(
  parameter int ADDR_BITS  = IMG_ADDR_BITS,
  parameter int DATA_WIDTH = IMG_DATA_WIDTH
) ();

  logic                  start;
  logic [ADDR_BITS-1:0]  base_addr;
  logic [ADDR_BITS:0]    length;
  logic                  busy;
  logic                  done;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_addr, length, mem_data, out_ready,
    output mem_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, length, mem_data, out_ready,
    input  mem_addr, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/image_mem_reader_stream_out_reg.sv
// Single-entry valid/ready output register.
//   load/load_data : capture a new byte (only honoured by the caller when can_load)
//   ready          : consumer accept
//   data/valid     : registered output
//   can_load       : register is empty or is being emptied this cycle
// An accepted byte with no replacement load empties the register.
module image_mem_reader_stream_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  can_load
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/image_mem_reader.sv
// Image buffer read streamer: on start, walks length bytes from base_addr
// (wrapping modulo depth) and emits them on a valid/ready stream.
//   clk, reset : clock, synchronous active-high reset
//   io         : command, memory read port and output stream (master side)
// mem_addr is the live read pointer, so the combinational memory read always
// presents the byte that the next load will capture.
module image_mem_reader
  import image_mem_reader_pkg::*;
#(
  parameter int ADDR_BITS  = IMG_ADDR_BITS,
  parameter int DATA_WIDTH = IMG_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  image_mem_reader_if.master  io
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_BITS:0]   LEN_ONE  = 1;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS:0]   rem;
  logic                 can_load;
  logic                 load;

  assign load        = (state == ST_STREAM) && can_load && (rem != '0);
  assign io.mem_addr = ptr;
  assign io.busy     = is_busy_state(state);
  assign io.done     = (state == ST_FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.start) begin
            if (io.length != '0) begin
              ptr   <= io.base_addr;
              rem   <= io.length;
              state <= ST_STREAM;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_STREAM: begin
          if (load) begin
            ptr <= ptr + ADDR_ONE;
            rem <= rem - LEN_ONE;
            if (rem == LEN_ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last byte is held in the output register until the consumer takes it.
          if (io.out_valid && io.out_ready) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  image_mem_reader_stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (io.mem_data),
    .ready     (io.out_ready),
    .data      (io.out_data),
    .valid     (io.out_valid),
    .can_load  (can_load)
  );

endmodule
